// File: rtl/uart_pkg.sv
// Shared definitions for the UART path: parity modes, TX state encoding
// and the bit-period helper used by the transmitter (and later the receiver).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and strobes `tick` for one
// cycle per period when the count equals TICK_AT. `clear` restarts the
// period at count 0. TICK_AT lets a user pick the strobe phase inside the
// bit (the transmitter wants it one cycle before the boundary, a receiver
// would want mid-bit).
module baud_tick #(
  parameter int CLKS_PER_BIT = 2,
  parameter int TICK_AT      = CLKS_PER_BIT - 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TICK_CNT = CW'(TICK_AT);

  logic [CW-1:0] count_reg;

  // Free-running period counter, restarted by reset or clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (count_reg == LAST_CNT) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == TICK_CNT);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_WIDTH data bits LSB
// first, optional parity, 1 or 2 stop bits. All outputs are registered.
// The baud timer strobes one cycle before each bit boundary; that early
// strobe is delayed into `bit_end_reg` (the last cycle of the bit), which
// drives the state changes, while `done` is raised directly from the early
// strobe so it lands in the final cycle of the last stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  line,
  output logic                  busy,
  output logic                  done
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUDRATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_frame: DATA_WIDTH must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLK_FREQ/BAUDRATE must be at least 2");
  end

  tx_state_t             state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [3:0]            bit_idx_reg;
  logic                  parity_reg;
  logic                  bit_end_reg;
  logic                  line_reg;
  logic                  ready_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  accept;
  logic                  tick;
  logic                  parity_calc;

  assign accept = ready_reg && valid;

  // Parity of the incoming word, captured together with the word on accept.
  always_comb begin
    parity_calc = ^data;
    if (PARITY == PAR_ODD) begin
      parity_calc = ~(^data);
    end
  end

  baud_tick #(
    .CLKS_PER_BIT(CPB),
    .TICK_AT     (CPB - 2)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(accept || bit_end_reg),
    .tick (tick)
  );

  // Frame sequencer with registered line/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      parity_reg  <= 1'b0;
      bit_end_reg <= 1'b0;
      line_reg    <= 1'b1;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      bit_end_reg <= tick && (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg   <= ST_START;
            shift_reg   <= data;
            parity_reg  <= parity_calc;
            bit_idx_reg <= '0;
            line_reg    <= 1'b0;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end_reg) begin
            state_reg <= ST_DATA;
            line_reg  <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        ST_DATA: begin
          if (bit_end_reg) begin
            if (bit_idx_reg == LAST_DATA) begin
              bit_idx_reg <= '0;
              if (PARITY != PAR_NONE) begin
                state_reg <= ST_PARITY;
                line_reg  <= parity_reg;
              end else begin
                state_reg <= ST_STOP;
                line_reg  <= 1'b1;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              line_reg    <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_reg) begin
            state_reg   <= ST_STOP;
            bit_idx_reg <= '0;
            line_reg    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick && bit_idx_reg == LAST_STOP) begin
            done_reg <= 1'b1;
          end
          if (bit_end_reg) begin
            if (bit_idx_reg == LAST_STOP) begin
              state_reg   <= ST_IDLE;
              bit_idx_reg <= '0;
              ready_reg   <= 1'b1;
              busy_reg    <= 1'b0;
              line_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          line_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign line  = line_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 7N2, all at 10
// clocks per bit). A frame-level model predicts every output on every cycle
// from the accept cycle and the frame's bit list; directed literal checks
// pin the model to hand-computed waveforms.
module tb_uart_tx_frame;

  localparam int CPB = 10;
  localparam int DWC [4] = '{8, 8, 8, 7};
  localparam int PARC[4] = '{0, 1, 2, 0};
  localparam int SBC [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst       [4];
  logic       valid_s   [4];
  logic [8:0] data_s    [4];
  logic       ready_s   [4];
  logic       line_s    [4];
  logic       busy_s    [4];
  logic       done_s    [4];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit armed = 1'b0;

  int          acc_m [4];
  logic [12:0] fb_m  [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(rst[0]), .valid(valid_s[0]), .data(data_s[0][7:0]),
    .ready(ready_s[0]), .line(line_s[0]), .busy(busy_s[0]), .done(done_s[0]));
  uart_tx_frame #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(rst[1]), .valid(valid_s[1]), .data(data_s[1][7:0]),
    .ready(ready_s[1]), .line(line_s[1]), .busy(busy_s[1]), .done(done_s[1]));
  uart_tx_frame #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(rst[2]), .valid(valid_s[2]), .data(data_s[2][7:0]),
    .ready(ready_s[2]), .line(line_s[2]), .busy(busy_s[2]), .done(done_s[2]));
  uart_tx_frame #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_WIDTH(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(rst[3]), .valid(valid_s[3]), .data(data_s[3][6:0]),
    .ready(ready_s[3]), .line(line_s[3]), .busy(busy_s[3]), .done(done_s[3]));

  task automatic chk(input string nm, input int c, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d cycle %0d got %b want %b", nm, c, cyc, act, exp);
    end
  endtask

  function automatic int frame_len(input int c);
    return (1 + DWC[c] + ((PARC[c] != 0) ? 1 : 0) + SBC[c]) * CPB;
  endfunction

  // Frame bit list: start, data LSB first, optional parity, stop bits.
  function automatic logic [12:0] frame_bits(input int c, input logic [8:0] d);
    logic [12:0] fb;
    logic        par;
    fb    = '1;
    fb[0] = 1'b0;
    par   = 1'b0;
    for (int i = 0; i < DWC[c]; i++) begin
      fb[1 + i] = d[i];
      par       = par ^ d[i];
    end
    if (PARC[c] == 1) fb[1 + DWC[c]] = par;
    if (PARC[c] == 2) fb[1 + DWC[c]] = ~par;
    return fb;
  endfunction

  // Per-cycle model and comparison for all channels.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      logic e_line, e_ready, e_busy, e_done;
      int   off;
      e_line = 1'b1; e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      if (acc_m[c] >= 0) begin
        off     = cyc - acc_m[c] - 1;
        e_line  = fb_m[c][off / CPB];
        e_ready = 1'b0;
        e_busy  = 1'b1;
        e_done  = (cyc == acc_m[c] + frame_len(c));
      end
      if (armed) begin
        chk("line", c, line_s[c], e_line);
        chk("ready", c, ready_s[c], e_ready);
        chk("busy", c, busy_s[c], e_busy);
        chk("done", c, done_s[c], e_done);
      end
      if (rst[c]) begin
        acc_m[c] = -1;
      end else if (e_ready && valid_s[c]) begin
        acc_m[c] = cyc;
        fb_m[c]  = frame_bits(c, data_s[c]);
      end else if (acc_m[c] >= 0 && cyc == acc_m[c] + frame_len(c)) begin
        acc_m[c] = -1;
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int c, input logic [8:0] w, output int acc);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!ready_s[c] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", c, ready_s[c], 1'b1);
    valid_s[c] = 1'b1;
    data_s[c]  = w;
    acc        = cyc;
    @(posedge clk); #1;
    valid_s[c] = 1'b0;
    data_s[c]  = 9'($urandom);
  endtask

  initial begin
    int a;
    logic [9:0] pat_a5;
    for (int c = 0; c < 4; c++) begin
      rst[c] = 1'b1; valid_s[c] = 1'b0; data_s[c] = '0; acc_m[c] = -1; fb_m[c] = '1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) rst[c] = 1'b0;
    armed = 1'b1;
    chk("rst_line", 0, line_s[0], 1'b1);
    chk("rst_ready", 0, ready_s[0], 1'b1);
    chk("rst_busy", 0, busy_s[0], 1'b0);
    chk("rst_done", 0, done_s[0], 1'b0);

    // 8N1 0xA5: transmitted bits, first bit in bit 0
    pat_a5 = 10'b1101001010;
    send(0, 9'h0A5, a);
    for (int i = 0; i < 10; i++) begin
      goto(a + 1 + 10 * i + 5);
      chk("a5_bit", 0, line_s[0], pat_a5[i]);
    end
    goto(a + 99);  chk("a5_nodone", 0, done_s[0], 1'b0);
    goto(a + 100); chk("a5_done", 0, done_s[0], 1'b1);
    goto(a + 101); chk("a5_ready", 0, ready_s[0], 1'b1);

    // Back-to-back: valid held high, 0x00 then 0xFF
    goto(a + 105);
    valid_s[0] = 1'b1; data_s[0] = 9'h000; a = cyc;
    goto(a + 1);   data_s[0] = 9'h0FF;
    goto(a + 100); chk("b2b_done1", 0, done_s[0], 1'b1);
    goto(a + 101); chk("b2b_gap", 0, line_s[0], 1'b1);
    goto(a + 102); chk("b2b_start2", 0, line_s[0], 1'b0);
    valid_s[0] = 1'b0;
    goto(a + 201); chk("b2b_done2", 0, done_s[0], 1'b1);

    // Mid-frame disturbance: data/valid change in bit 2, reset in bit 3
    send(0, 9'h0A5, a);
    goto(a + 35);
    valid_s[0] = 1'b1; data_s[0] = 9'h05A;
    @(posedge clk); #1;
    valid_s[0] = 1'b0;
    goto(a + 45);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("rst_mid_line", 0, line_s[0], 1'b1);
    chk("rst_mid_ready", 0, ready_s[0], 1'b1);
    chk("rst_mid_busy", 0, busy_s[0], 1'b0);
    send(0, 9'h03C, a);
    goto(a + 1 + 30 + 5); chk("3c_bit2", 0, line_s[0], 1'b1);
    goto(a + 100); chk("3c_done", 0, done_s[0], 1'b1);

    // Parity channels, 0x07
    send(1, 9'h007, a);
    goto(a + 96);  chk("even_par", 1, line_s[1], 1'b1);
    goto(a + 110); chk("even_done", 1, done_s[1], 1'b1);
    send(2, 9'h007, a);
    goto(a + 96);  chk("odd_par", 2, line_s[2], 1'b0);
    goto(a + 110); chk("odd_done", 2, done_s[2], 1'b1);

    // 7N2, 0x55
    send(3, 9'h055, a);
    goto(a + 81);  chk("7n2_stop_a", 3, line_s[3], 1'b1);
    goto(a + 100); chk("7n2_stop_b", 3, line_s[3], 1'b1);
    chk("7n2_done", 3, done_s[3], 1'b1);
    goto(a + 101); chk("7n2_ready", 3, ready_s[3], 1'b1);

    // Randomised traffic with occasional resets on every channel
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
        rst[c]     = ($urandom_range(0, 499) == 0);
        valid_s[c] = ($urandom_range(0, 1) == 1);
        data_s[c]  = 9'($urandom);
      end
    end
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      rst[c] = 1'b0; valid_s[c] = 1'b0;
    end
    goto(cyc + 150);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
